// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle HI/LO multiply/divide sequencer for the EX stage.
// Executes MULT/MULTU with a radix-2 shift-add multiplier and DIV/DIVU with a
// restoring divider. It owns the architectural HI/LO registers and handles
// MTHI/MTLO writes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      EX-stage instruction is an MDU op; held while it sits in EX
//   md_op      one-hot op: [0] mult [1] multu [2] div [3] divu [4] mthi [5] mtlo
//   src1       rs operand (multiplicand / dividend / mthi-mtlo data)
//   src2       rt operand (multiplier / divisor)
//   flush      kills any operation in flight; suppresses accept
//   stall_req  combinational hold request for IF/ID/EX
//   busy       sequencer is not idle
//   done       one-cycle pulse while in FIN
//   hi, lo     architectural HI/LO registers
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        md_op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              flush,
    output logic              stall_req,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t              state_reg;
    logic [4:0]          cnt_reg;
    logic [DATA_W:0]     acc_reg;      // multiply upper half / divide remainder
    logic [DATA_W-1:0]   work_reg;     // multiplier bits / dividend-quotient
    logic [DATA_W-1:0]   opb_reg;      // multiplicand / divisor magnitude
    logic                is_div_reg;
    logic                no_write_reg;
    logic                neg_reg;      // product sign or quotient sign
    logic                neg_r_reg;    // remainder sign
    logic                done_reg;
    logic [DATA_W-1:0]   hi_reg;
    logic [DATA_W-1:0]   lo_reg;

    // Operand magnitudes; 0x80000000 negates to itself, which is the correct
    // unsigned magnitude.
    logic              is_signed;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic              accept;

    assign is_signed = md_op[0] | md_op[2];
    assign mag1      = (is_signed && src1[DATA_W-1]) ? (~src1 + 1'b1) : src1;
    assign mag2      = (is_signed && src2[DATA_W-1]) ? (~src2 + 1'b1) : src2;
    assign accept    = start && (state_reg == IDLE) && !flush;

    // One shift-add multiply step: add, then shift {upper, lower} right.
    logic [DATA_W:0]   mul_sum;
    assign mul_sum = work_reg[0] ? (acc_reg + {1'b0, opb_reg}) : acc_reg;

    // One restoring divide step. Two guard bits keep the sign of the trial
    // subtraction unambiguous.
    logic [DATA_W+1:0] div_diff;
    logic              div_ok;
    assign div_diff = {1'b0, acc_reg[DATA_W-1:0], work_reg[DATA_W-1]}
                    - {2'b00, opb_reg};
    assign div_ok   = ~div_diff[DATA_W+1];

    // Sign-corrected results used in FIN.
    logic [2*DATA_W-1:0] prod_raw;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    assign prod_raw = {acc_reg[DATA_W-1:0], work_reg};
    assign prod_fix = neg_reg   ? (~prod_raw + 1'b1) : prod_raw;
    assign quo_fix  = neg_reg   ? (~work_reg + 1'b1) : work_reg;
    assign rem_fix  = neg_r_reg ? (~acc_reg[DATA_W-1:0] + 1'b1)
                                : acc_reg[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            work_reg     <= '0;
            opb_reg      <= '0;
            is_div_reg   <= 1'b0;
            no_write_reg <= 1'b0;
            neg_reg      <= 1'b0;
            neg_r_reg    <= 1'b0;
            done_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else if (flush) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (md_op[0] || md_op[1]) begin
                            opb_reg    <= mag1;
                            work_reg   <= mag2;
                            acc_reg    <= '0;
                            neg_reg    <= md_op[0] & (src1[DATA_W-1] ^ src2[DATA_W-1]);
                            is_div_reg <= 1'b0;
                            cnt_reg    <= '0;
                            state_reg  <= MUL;
                        end else if (md_op[2] || md_op[3]) begin
                            work_reg     <= mag1;
                            opb_reg      <= mag2;
                            acc_reg      <= '0;
                            neg_reg      <= md_op[2] & (src1[DATA_W-1] ^ src2[DATA_W-1]);
                            neg_r_reg    <= md_op[2] & src1[DATA_W-1];
                            is_div_reg   <= 1'b1;
                            cnt_reg      <= '0;
                            no_write_reg <= (src2 == '0);
                            if (src2 == '0) begin
                                state_reg <= FIN;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= DIV;
                            end
                        end else if (md_op[4]) begin
                            hi_reg <= src1;
                        end else if (md_op[5]) begin
                            lo_reg <= src1;
                        end
                    end
                end
                MUL: begin
                    acc_reg  <= {1'b0, mul_sum[DATA_W:1]};
                    work_reg <= {mul_sum[0], work_reg[DATA_W-1:1]};
                    cnt_reg  <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        state_reg    <= FIN;
                        done_reg     <= 1'b1;
                        no_write_reg <= 1'b0;
                    end
                end
                DIV: begin
                    acc_reg  <= div_ok ? {1'b0, div_diff[DATA_W-1:0]}
                                       : {1'b0, acc_reg[DATA_W-2:0], work_reg[DATA_W-1]};
                    work_reg <= {work_reg[DATA_W-2:0], div_ok};
                    cnt_reg  <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        state_reg <= FIN;
                        done_reg  <= 1'b1;
                    end
                end
                FIN: begin
                    if (!no_write_reg) begin
                        if (is_div_reg) begin
                            lo_reg <= quo_fix;
                            hi_reg <= rem_fix;
                        end else begin
                            hi_reg <= prod_fix[2*DATA_W-1:DATA_W];
                            lo_reg <= prod_fix[DATA_W-1:0];
                        end
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Low in FIN so the instruction leaves EX on the edge that writes HI/LO.
    assign stall_req = (start && (md_op[3:0] != 4'b0) && (state_reg == IDLE) && !flush)
                     || (state_reg == MUL) || (state_reg == DIV);
    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the driver pushes expected {HI,LO} for
// each mult/div, a monitor pops and compares one cycle after every done pulse.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  md_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_done_cnt = 0;
    logic [63:0] exp_q[$];

    localparam logic [5:0] OP_MULT  = 6'b000001;
    localparam logic [5:0] OP_MULTU = 6'b000010;
    localparam logic [5:0] OP_DIV   = 6'b000100;
    localparam logic [5:0] OP_DIVU  = 6'b001000;
    localparam logic [5:0] OP_MTHI  = 6'b010000;
    localparam logic [5:0] OP_MTLO  = 6'b100000;

    mul_div_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .md_op(md_op),
        .src1(src1), .src2(src2), .flush(flush),
        .stall_req(stall_req), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end else begin
            $display("ok   %s value=%h", nm, act);
        end
    endtask

    // Monitor: result is visible the cycle after done.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                @(posedge clk);
                #1;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {hi, lo}, 64'hx);
                end else begin
                    check("result_hilo", {hi, lo}, exp_q.pop_front());
                end
            end
        end
    end

    // Issue one op and hold start until done is seen (through FIN).
    // exp_done < 0 means no done expected (mthi/mtlo): only cycle T is observed.
    task automatic run_op(input string nm, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int exp_stall, input int exp_done);
        int stall_cnt;
        int done_at;
        stall_cnt = 0;
        done_at = -1;
        if (exp_done >= 0) begin
            exp_q.push_back({eh, el});
            exp_done_cnt++;
        end
        @(posedge clk);
        #1;
        start = 1'b1; md_op = op; src1 = a; src2 = b;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (stall_req) stall_cnt++;
            if (done && done_at < 0) done_at = k;
            if (done_at >= 0 || exp_done < 0) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        start = 1'b0; md_op = '0;
        check({nm, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
        check({nm, "_done_cycle"}, 64'(done_at), 64'(exp_done));
    endtask

    initial begin
        int base;
        rst = 1'b1; start = 1'b0; md_op = '0; src1 = '0; src2 = '0; flush = 1'b0;
        #12;
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_flags", {61'h0, stall_req, busy, done}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mult_m3x7",   OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33, 33);
        run_op("multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33);
        run_op("mult_min",    OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 33);
        run_op("multu_shift", OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 33, 33);
        run_op("div_m7_2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33);
        run_op("div_7_m2",    OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 33);
        run_op("divu_7_2",    OP_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 33, 33);
        run_op("divu_100_7",  OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33, 33);
        run_op("div_min_m1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 33);

        // Divide by zero leaves preloaded HI/LO untouched.
        run_op("mthi_a", OP_MTHI, 32'hA, 32'h0, 32'h0, 32'h0, 0, -1);
        run_op("mtlo_b", OP_MTLO, 32'hB, 32'h0, 32'h0, 32'h0, 0, -1);
        check("preload_hilo", {hi, lo}, {32'hA, 32'hB});
        run_op("div_by_zero", OP_DIV, 32'd5, 32'd0, 32'hA, 32'hB, 1, 1);
        @(negedge clk);
        check("dbz_idle_busy", {63'h0, busy}, 64'h0);

        // Asynchronous reset mid-multiply clears HI/LO before the next edge.
        @(posedge clk);
        #1;
        start = 1'b1; md_op = OP_MULT; src1 = 32'd7; src2 = 32'd9;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1; start = 1'b0; md_op = '0;
        #1;
        check("rst_mid_hilo", {hi, lo}, 64'h0);
        check("rst_mid_flags", {61'h0, stall_req, busy, done}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Flush mid-multiply: back to IDLE, no done, no write.
        base = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1; md_op = OP_MULT; src1 = 32'd5; src2 = 32'd5;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b0; md_op = '0;
        @(negedge clk);
        check("flush_t10_stall", {63'h0, stall_req}, 64'h1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_t11_flags", {62'h0, stall_req, busy}, 64'h0);
        repeat (40) @(negedge clk);
        check("flush_no_done", 64'(done_cnt - base), 64'h0);
        check("flush_hilo", {hi, lo}, 64'h0);

        // Flush in IDLE suppresses mthi.
        @(posedge clk);
        #1;
        start = 1'b1; md_op = OP_MTHI; src1 = 32'hDEAD; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = '0; flush = 1'b0;
        check("flush_mthi_hi", {32'h0, hi}, 64'h0);

        // mthi visible at T+1 with no stall.
        run_op("mthi_val", OP_MTHI, 32'h12345678, 32'h0, 32'h0, 32'h0, 0, -1);
        check("mthi_hi", {32'h0, hi}, {32'h0, 32'h12345678});

        // Start held through FIN: exactly one done and one write.
        base = done_cnt;
        run_op("mult_hold", OP_MULT, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 33, 33);
        repeat (5) @(negedge clk);
        check("hold_one_done", 64'(done_cnt - base), 64'h1);

        repeat (3) @(negedge clk);
        check("total_dones", 64'(done_cnt), 64'(exp_done_cnt));
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: any hang is reported as a failure and the run still summarises.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
